// File: rtl/pm_loader.sv
// pm_loader: boot loader; byte stream (in_valid/in_ready/in_byte) -> big-endian words on pm_we/pm_addr/pm_wdata, zero-fills the rest, cpu_hold/busy/done/err/word_count status
module pm_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  in_ready,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [DATA_WIDTH-1:0] pm_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);
  typedef enum logic [2:0] {IDLE, HDR, HI, LO, WR, FILL, DONE, ERR} state_t;
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_N = AW1'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] n_q, n_d, wc_q, wc_d, ptr_nx;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, pm_addr_q, pm_addr_d;
  logic [7:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] pm_wdata_q, pm_wdata_d;
  logic in_ready_q, in_ready_d, pm_we_q, pm_we_d, hold_q, hold_d;
  logic busy_q, busy_d, done_q, done_d, err_q, err_d, xfer;
  assign xfer   = in_valid && in_ready_q;
  assign ptr_nx = {1'b0, ptr_q} + AW1'(1);
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    wc_d       = wc_q;
    ptr_d      = ptr_q;
    hi_d       = hi_q;
    pm_addr_d  = pm_addr_q;
    pm_wdata_d = pm_wdata_q;
    pm_we_d    = 1'b0;
    done_d     = 1'b0;
    hold_d     = hold_q;
    busy_d     = busy_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = HDR;
        wc_d    = '0;
        err_d   = 1'b0;
        hold_d  = 1'b1;
        busy_d  = 1'b1;
      end
      HDR: if (xfer) begin
        n_d   = in_byte[ADDR_WIDTH:0];
        ptr_d = '0;
        if (in_byte == 8'd0 || in_byte > DEPTH_B) begin
          state_d = ERR;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else state_d = HI;
      end
      HI: if (xfer) begin
        hi_d    = in_byte;
        state_d = LO;
      end
      LO: if (xfer) begin
        state_d    = WR;
        pm_we_d    = 1'b1;
        pm_addr_d  = ptr_q;
        pm_wdata_d = DATA_WIDTH'({hi_q, in_byte});
      end
      WR: begin
        ptr_d = ptr_nx[ADDR_WIDTH-1:0];
        wc_d  = wc_q + AW1'(1);
        if (ptr_nx != n_q) state_d = HI;
        else if (n_q == DEPTH_N) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = FILL;
          pm_we_d    = 1'b1;
          pm_addr_d  = ptr_nx[ADDR_WIDTH-1:0];
          pm_wdata_d = '0;
        end
      end
      FILL: if (ptr_q == LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        ptr_d      = ptr_nx[ADDR_WIDTH-1:0];
        pm_we_d    = 1'b1;
        pm_addr_d  = ptr_nx[ADDR_WIDTH-1:0];
        pm_wdata_d = '0;
      end
      DONE: begin
        state_d = IDLE;
        hold_d  = 1'b0;
        busy_d  = 1'b0;
      end
      ERR: if (start) begin
        state_d = HDR;
        wc_d    = '0;
        err_d   = 1'b0;
        busy_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == HDR) || (state_d == HI) || (state_d == LO);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      n_q        <= '0;
      wc_q       <= '0;
      ptr_q      <= '0;
      hi_q       <= '0;
      pm_addr_q  <= '0;
      pm_wdata_q <= '0;
      pm_we_q    <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      wc_q       <= wc_d;
      ptr_q      <= ptr_d;
      hi_q       <= hi_d;
      pm_addr_q  <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      pm_we_q    <= pm_we_d;
      done_q     <= done_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
    end
  end
  assign in_ready   = in_ready_q;
  assign pm_we      = pm_we_q;
  assign pm_addr    = pm_addr_q;
  assign pm_wdata   = pm_wdata_q;
  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign word_count = wc_q;
endmodule

// File: tb/tb_pm_loader.sv
// tb_pm_loader: scoreboard bench for pm_loader
module tb_pm_loader;
  logic clk = 0, rst = 1, start = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic in_ready, pm_we, cpu_hold, busy, done, err;
  logic [4:0] pm_addr;
  logic [15:0] pm_wdata;
  logic [5:0] word_count;
  logic [20:0] exp_q[$];
  logic [15:0] words[$];
  int pass_cnt = 0, chk_cnt = 0, cyc = 0, start_cyc = 0;

  pm_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  always @(negedge clk) if (pm_we) begin
    if (rst) begin
      chk_cnt++;
      $display("FAIL write_in_reset: addr %0d data %h", pm_addr, pm_wdata);
    end else if (exp_q.size() == 0) begin
      chk_cnt++;
      $display("FAIL unexpected_write: addr %0d data %h", pm_addr, pm_wdata);
    end else check("write{addr,data}", {pm_addr, pm_wdata}, exp_q.pop_front());
  end

  task automatic check_idle(string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_pm_we"}, pm_we, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_word_count"}, word_count, 0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_byte  = b;
    in_valid = 1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: byte %h never accepted", b);
      in_valid = 0;
      return;
    end
    @(negedge clk);
    in_valid = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1;
    start_cyc = cyc;
    @(negedge clk);
    start = 0;
  endtask

  task automatic push_exp();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({5'(i), (i < words.size()) ? words[i] : 16'h0000});
  endtask

  task automatic wait_done(input int exp_edge, input int exp_wc);
    for (int k = 0; k < 400 && !done; k++) @(negedge clk);
    if (!done) begin
      chk_cnt++;
      $display("FAIL done_timeout: done never rose");
      return;
    end
    if (exp_edge >= 0) check("done_edge", cyc - start_cyc - 1, exp_edge);
    check("word_count", word_count, exp_wc);
    check("hold_at_done", cpu_hold, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("hold_after_done", cpu_hold, 0);
    check("busy_after_done", busy, 0);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic run_load(input int gap, input int exp_edge);
    push_exp();
    pulse_start();
    check("err_cleared", err, 0);
    check("busy_set", busy, 1);
    check("hold_set", cpu_hold, 1);
    send(8'(words.size()), gap);
    foreach (words[i]) begin
      send(words[i][15:8], gap);
      send(words[i][7:0], gap);
    end
    wait_done(exp_edge, words.size());
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 0;
    @(negedge clk);
    // normal load: 03 B2 03 B3 05 04 64, done 3N+(32-N)+1 = 39 edges after start
    words = '{16'hB203, 16'hB305, 16'h0464};
    run_load(0, 39);
    // same stream with 4-cycle gaps between bytes
    run_load(4, -1);
    // bad header N=0
    pulse_start();
    send(8'd0, 0);
    check("n0_err", err, 1);
    check("n0_busy", busy, 0);
    check("n0_hold", cpu_hold, 1);
    check("n0_in_ready", in_ready, 0);
    repeat (5) @(negedge clk);
    check("n0_err_sticky", err, 1);
    // bad header N=33, started from the error state
    pulse_start();
    check("n33_err_cleared", err, 0);
    send(8'd33, 0);
    check("n33_err", err, 1);
    check("n33_busy", busy, 0);
    check("n33_hold", cpu_hold, 1);
    repeat (3) @(negedge clk);
    // recovery with N=1
    words = '{16'h1234};
    run_load(0, 35);
    // full load N=32
    words.delete();
    for (int i = 0; i < 32; i++) words.push_back({8'(8'h10 + i), 8'(8'hF0 - i)});
    run_load(0, 97);
    // start pulsed during HI is ignored
    words = '{16'hDEAD, 16'hBEEF};
    push_exp();
    pulse_start();
    send(8'd2, 0);
    start = 1;
    @(negedge clk);
    start = 0;
    check("hi_start_busy", busy, 1);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    wait_done(-1, 2);
    // reset during FILL
    words = '{16'h00FF};
    push_exp();
    pulse_start();
    send(8'd1, 0); send(8'h00, 0); send(8'hFF, 0);
    for (int k = 0; k < 100 && !(pm_we && pm_addr == 5'd10); k++) @(negedge clk);
    check("fill_reached_10", {pm_we, pm_addr}, {1'b1, 5'd10});
    #1 rst = 1;
    @(negedge clk);
    check_idle("fill_rst");
    @(negedge clk);
    check("fill_rst_hold2", cpu_hold, 0);
    exp_q.delete();
    rst = 0;
    @(negedge clk);
    words = '{16'hCAFE, 16'h0001};
    run_load(0, 37);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
